// File: rtl/imm_gen_if.sv
// imm_gen_if: instruction-in / immediate-out handshake bundle for imm_gen_stage.
// The master side is the producer of instructions and the consumer of
// immediates (ID front-end / EX); the slave side is the stage itself.
interface imm_gen_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    // upstream (ID decode -> stage)
    logic             valid_i;
    logic             ready_o;
    logic [31:0]      instr_i;
    logic [TAG_W-1:0] tag_i;
    // downstream (stage -> EX)
    logic             valid_o;
    logic             ready_i;
    logic [XLEN-1:0]  imm_o;
    logic [2:0]       fmt_o;
    logic             illegal_o;
    logic [TAG_W-1:0] tag_o;

    modport master (
        output valid_i, instr_i, tag_i, ready_i,
        input  ready_o, valid_o, imm_o, fmt_o, illegal_o, tag_o
    );

    modport slave (
        input  valid_i, instr_i, tag_i, ready_i,
        output ready_o, valid_o, imm_o, fmt_o, illegal_o, tag_o
    );
endinterface

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered RV32I/RV64I immediate generator with a 2-entry
// skid buffer (OUT + SKID). ready_o is a flop, so EX back-pressure never
// reaches the upstream ready combinationally.
// Optional feature macro: IMM_GEN_ZICSR_EN (CSR*I uimm decode, fmt 6).
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    imm_gen_if.slave    bus
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_stage: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_ZICSR_EN
    localparam logic [2:0] FMT_Z    = 3'd6;
`endif

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    entry_t          dec;

    assign instr  = bus.instr_i;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Sized signed casts sign-extend straight to XLEN; shamt is zero-extended
    // and gains bit 25 only in RV64.
    assign imm_i  = XLEN'($signed(instr[31:20]));
    assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b  = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    assign imm_sh = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);

    // Format decode of the incoming instruction into a pipeline entry.
    always_comb begin
        dec         = '0;
        dec.tag     = bus.tag_i;
        unique case (opcode)
            OPC_LOAD, OPC_JALR: begin
                dec.fmt = FMT_I;
                dec.imm = imm_i;
            end
            OPC_OP_IMM: begin
                dec.fmt = FMT_I;
                dec.imm = (funct3 == 3'b001 || funct3 == 3'b101) ? imm_sh : imm_i;
            end
            OPC_STORE: begin
                dec.fmt = FMT_S;
                dec.imm = imm_s;
            end
            OPC_BRANCH: begin
                dec.fmt = FMT_B;
                dec.imm = imm_b;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.fmt = FMT_U;
                dec.imm = imm_u;
            end
            OPC_JAL: begin
                dec.fmt = FMT_J;
                dec.imm = imm_j;
            end
            OPC_OP: begin
                dec.fmt = FMT_NONE;
            end
            OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
                if (funct3 == 3'b101 || funct3 == 3'b110 || funct3 == 3'b111) begin
                    dec.fmt = FMT_Z;
                    dec.imm = XLEN'(instr[19:15]);
                end else begin
                    dec.fmt = FMT_NONE;
                end
`else
                dec.fmt = FMT_NONE;
`endif
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    // Skid pipeline state.
    entry_t out_q, out_d, skid_q, skid_d;
    logic   out_vld, out_vld_d, skid_vld, skid_vld_d, rdy_q;
    logic   accept, out_load;

    assign accept   = bus.valid_i & rdy_q;
    assign out_load = ~out_vld | bus.ready_i;

    // Next-state: SKID drains into OUT first (ready_o is low then, so no
    // accept can collide); otherwise input goes to OUT if it can move,
    // else parks in SKID. Flush overrides everything but reset.
    always_comb begin
        out_d      = out_q;
        skid_d     = skid_q;
        out_vld_d  = out_vld;
        skid_vld_d = skid_vld;
        if (flush_i) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (out_load) begin
            if (skid_vld) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = accept;
                if (accept) out_d = dec;
            end
        end else if (accept) begin
            skid_d     = dec;
            skid_vld_d = 1'b1;
        end
    end

    // State registers; ready_o is registered from the next SKID occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            skid_q   <= '0;
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            out_q    <= out_d;
            skid_q   <= skid_d;
            out_vld  <= out_vld_d;
            skid_vld <= skid_vld_d;
            rdy_q    <= ~skid_vld_d;
        end
    end

    assign bus.ready_o   = rdy_q;
    assign bus.valid_o   = out_vld;
    assign bus.imm_o     = out_q.imm;
    assign bus.fmt_o     = out_q.fmt;
    assign bus.illegal_o = out_q.illegal;
    assign bus.tag_o     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: drives an XLEN=32 and an XLEN=64 instance with identical
// stimulus; a scoreboard of model results is filled on accept and drained on
// each output transfer. Honours IMM_GEN_ZICSR_EN like the design.
module tb_imm_gen_stage;

    logic clk, rst, flush;
    logic valid, ready;
    logic [31:0] instr, tg;
    bit rnd;

    imm_gen_if #(.XLEN(32), .TAG_W(32)) b32 ();
    imm_gen_if #(.XLEN(64), .TAG_W(32)) b64 ();

    assign b32.valid_i = valid;  assign b64.valid_i = valid;
    assign b32.instr_i = instr;  assign b64.instr_i = instr;
    assign b32.tag_i   = tg;     assign b64.tag_i   = tg;
    assign b32.ready_i = ready;  assign b64.ready_i = ready;

    imm_gen_stage #(.XLEN(32), .TAG_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .flush_i(flush), .bus(b32));
    imm_gen_stage #(.XLEN(64), .TAG_W(32)) u_dut64 (
        .clk(clk), .rst(rst), .flush_i(flush), .bus(b64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] i32;
        logic [63:0] i64;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    // Reference decode written from the ISA immediate layouts.
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] t);
        exp_t e;
        logic [63:0] v;
        e.tag = t; e.fmt = 3'd0; e.ill = 1'b0; v = 64'd0;
        case (w[6:0])
            7'h03, 7'h67: begin e.fmt = 3'd1; v = {{52{w[31]}}, w[31:20]}; end
            7'h13:        begin e.fmt = 3'd1; v = {{52{w[31]}}, w[31:20]}; end
            7'h23: begin e.fmt = 3'd2; v = {{52{w[31]}}, w[31:25], w[11:7]}; end
            7'h63: begin e.fmt = 3'd3; v = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0}; end
            7'h37, 7'h17: begin e.fmt = 3'd4; v = {{32{w[31]}}, w[31:12], 12'h000}; end
            7'h6F: begin e.fmt = 3'd5; v = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; end
            7'h33: ;
            7'h73: begin
`ifdef IMM_GEN_ZICSR_EN
                if (w[14] && w[13:12] != 2'b00) begin e.fmt = 3'd6; v = {59'd0, w[19:15]}; end
`endif
            end
            default: e.ill = 1'b1;
        endcase
        e.i64 = v;
        e.i32 = v[31:0];
        if (w[6:0] == 7'h13 && w[13:12] == 2'b01) begin
            e.i32 = {27'd0, w[24:20]};
            e.i64 = {58'd0, w[25:20]};
        end
        return e;
    endfunction

    exp_t sb[$];

    // Output-stability snapshot while stalled.
    bit          held;
    logic [31:0] s_imm32, s_tag;
    logic [63:0] s_imm64;
    logic [2:0]  s_fmt;
    logic        s_ill;

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst || flush) begin
            sb.delete();
            held = 1'b0;
        end else begin
            if (held && b32.valid_o) begin
                chk("stall_imm32", b32.imm_o, s_imm32);
                chk("stall_imm64", b64.imm_o, s_imm64);
                chk("stall_fmt",   b32.fmt_o, s_fmt);
                chk("stall_ill",   b32.illegal_o, s_ill);
                chk("stall_tag",   b32.tag_o, s_tag);
            end
            held = b32.valid_o && !ready;
            s_imm32 = b32.imm_o; s_imm64 = b64.imm_o; s_fmt = b32.fmt_o;
            s_ill = b32.illegal_o; s_tag = b32.tag_o;
            if (b32.valid_o && ready) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("imm32", b32.imm_o, e.i32);
                    chk("imm64", b64.imm_o, e.i64);
                    chk("vld64", b64.valid_o, 1);
                    chk("fmt32", b32.fmt_o, e.fmt);
                    chk("fmt64", b64.fmt_o, e.fmt);
                    chk("ill32", b32.illegal_o, e.ill);
                    chk("ill64", b64.illegal_o, e.ill);
                    chk("tag32", b32.tag_o, e.tag);
                    chk("tag64", b64.tag_o, e.tag);
                end
            end
            if (valid && b32.ready_o) sb.push_back(model(instr, tg));
        end
    end

    // Present one instruction until accepted; valid is left asserted.
    task automatic push(input logic [31:0] w, input logic [31:0] t);
        instr = w; tg = t; valid = 1'b1;
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            if (b32.ready_o) begin
                @(posedge clk); #1;
                if (rnd) ready = ($urandom_range(0, 3) != 0);
                return;
            end
            @(posedge clk); #1;
            if (rnd) ready = ($urandom_range(0, 3) != 0);
        end
        chk("push_timeout", 0, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vld"},   b32.valid_o, 0);
        chk({tag, "_rdy"},   b32.ready_o, 1);
        chk({tag, "_imm"},   b32.imm_o, 0);
        chk({tag, "_fmt"},   b32.fmt_o, 0);
        chk({tag, "_ill"},   b32.illegal_o, 0);
        chk({tag, "_tag"},   b32.tag_o, 0);
        chk({tag, "_vld64"}, b64.valid_o, 0);
        chk({tag, "_imm64"}, b64.imm_o, 0);
    endtask

    // Directed vector: one-cycle latency plus hand-derived expectations.
    task automatic vec(input logic [31:0] w, input logic [31:0] e32, input logic [63:0] e64,
                       input logic [2:0] f, input logic il);
        ready = 1'b1;
        push(w, w ^ 32'h5A5A0000);
        valid = 1'b0;
        @(negedge clk);
        chk("lat_vld", b32.valid_o, 1);
        chk("vec_imm32", b32.imm_o, e32);
        chk("vec_imm64", b64.imm_o, e64);
        chk("vec_fmt", b32.fmt_o, f);
        chk("vec_ill", b32.illegal_o, il);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        valid = 1'b0; ready = 1'b1; rnd = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !b32.valid_o) break;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    localparam logic [6:0] OPS [10] = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63,
                                        7'h37, 7'h17, 7'h6F, 7'h33, 7'h73};

    initial begin
        logic [31:0] w;
        rst = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b1; rnd = 1'b0;
        instr = '0; tg = '0; held = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Decode vectors
        vec(32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        vec(32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
        vec(32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0);
        vec(32'h001000EF, 32'h00000800, 64'h0000000000000800, 3'd5, 1'b0);
        vec(32'h0000007F, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b1);
        vec(32'h800002B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
        vec(32'h03F01093, 32'h0000001F, 64'h000000000000003F, 3'd1, 1'b0);
        vec(32'h00208033, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b0);
`ifdef IMM_GEN_ZICSR_EN
        vec(32'h3002D073, 32'h00000005, 64'h0000000000000005, 3'd6, 1'b0);
`else
        vec(32'h3002D073, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b0);
`endif
        drain();

        // Back-pressure: A to OUT, B to SKID, C held off
        ready = 1'b0;
        push(32'h00100093, 32'hA);
        push(32'h00200093, 32'hB);
        instr = 32'h00300093; tg = 32'hC; valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_rdy", b32.ready_o, 0);
            chk("bp_vld", b32.valid_o, 1);
            chk("bp_tag", b32.tag_o, 32'hA);
            @(posedge clk); #1;
        end
        ready = 1'b1;
        push(32'h00300093, 32'hC);
        drain();

        // Flush with both entries full and input presented
        ready = 1'b0;
        push(32'h00400093, 32'hD);
        push(32'h00500093, 32'hE);
        instr = 32'h00600093; tg = 32'hF; valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; valid = 1'b0;
        @(negedge clk);
        chk("flush_vld", b32.valid_o, 0);
        chk("flush_rdy", b32.ready_o, 1);
        ready = 1'b1;
        drain();

        // Reset mid-stall
        ready = 1'b0;
        push(32'h00700093, 32'h11);
        push(32'h00800093, 32'h12);
        valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst_stall");
        @(posedge clk); #1;
        rst = 1'b0; ready = 1'b1;
        drain();

        // Random instructions with random back-pressure
        rnd = 1'b1;
        for (int i = 0; i < 60; i++) begin
            w = $urandom;
            w[6:0] = (i % 11 == 10) ? 7'h5B : OPS[$urandom_range(0, 9)];
            push(w, 32'h1000 + i);
            if ($urandom_range(0, 2) == 0) begin
                valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
